// File: rtl/vec_pkg.sv
// Shared encodings for the element-serial vector execution unit.
package vec_pkg;

    // Elements per vector, fixed by the vector register file
    localparam int N_ELEM = 5;

    // Width of the element index counter
    localparam int IDX_W = 3;

    // Index of the final element processed before write-back
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    // Operation codes as driven by the control unit
    typedef enum logic [1:0] {
        OP_VADD = 2'b00,
        OP_VSUB = 2'b01,
        OP_VMUL = 2'b10,
        OP_VDOT = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/vec_elem_alu.sv
// Single-element arithmetic unit, time-multiplexed across vector elements.
// All results wrap modulo 2^WIDTH; the product is sign-agnostic low bits.
module vec_elem_alu
    import vec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] prodLow;

    assign prodLow = a_i * b_i;

    // Select the element result; the dot product reuses the plain product
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_VADD: y_o = a_i + b_i;
            OP_VSUB: y_o = a_i - b_i;
            OP_VMUL: y_o = prodLow;
            OP_VDOT: y_o = prodLow;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_seq.sv
// Element-serial vector execution unit. Latches two source vectors on start,
// processes one element per cycle, then pulses a one-cycle write-back of
// either the result vector or the dot-product scalar.
module vec_exec_seq
    import vec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [3:0]       vd_in,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] a_4,
    input  logic [WIDTH-1:0] b_0,
    input  logic [WIDTH-1:0] b_1,
    input  logic [WIDTH-1:0] b_2,
    input  logic [WIDTH-1:0] b_3,
    input  logic [WIDTH-1:0] b_4,
    output logic             busy,
    output logic             done,
    output logic             we_v,
    output logic             we_s,
    output logic [3:0]       vd_out,
    output logic [WIDTH-1:0] res_0,
    output logic [WIDTH-1:0] res_1,
    output logic [WIDTH-1:0] res_2,
    output logic [WIDTH-1:0] res_3,
    output logic [WIDTH-1:0] res_4,
    output logic [WIDTH-1:0] dot
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    op_e              opL_q;
    logic [3:0]       vd_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] dot_q;
    logic             busy_q;
    logic             done_q;
    logic             weV_q;
    logic             weS_q;
    logic [WIDTH-1:0] a_q   [N_ELEM];
    logic [WIDTH-1:0] b_q   [N_ELEM];
    logic [WIDTH-1:0] res_q [N_ELEM];

    logic [WIDTH-1:0] aIn [N_ELEM];
    logic [WIDTH-1:0] bIn [N_ELEM];
    logic [WIDTH-1:0] elemA;
    logic [WIDTH-1:0] elemB;
    logic [WIDTH-1:0] elemY;
    logic [WIDTH-1:0] acc_d;

    assign aIn[0] = a_0;
    assign aIn[1] = a_1;
    assign aIn[2] = a_2;
    assign aIn[3] = a_3;
    assign aIn[4] = a_4;
    assign bIn[0] = b_0;
    assign bIn[1] = b_1;
    assign bIn[2] = b_2;
    assign bIn[3] = b_3;
    assign bIn[4] = b_4;

    // Pick the latched operand pair for the current element; out-of-range
    // indices yield zero so the mux never reads past the latch array
    always_comb begin
        elemA = '0;
        elemB = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                elemA = a_q[i];
                elemB = b_q[i];
            end
        end
    end

    vec_elem_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op_i(opL_q),
        .a_i (elemA),
        .b_i (elemB),
        .y_o (elemY)
    );

    assign acc_d = acc_q + elemY;

    // Sequencer, operand latches, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opL_q   <= OP_VADD;
            vd_q    <= '0;
            acc_q   <= '0;
            dot_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            weV_q   <= 1'b0;
            weS_q   <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            weV_q  <= 1'b0;
            weS_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            a_q[i] <= aIn[i];
                            b_q[i] <= bIn[i];
                        end
                        opL_q   <= op_e'(op);
                        vd_q    <= vd_in;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (idx_q > LAST_IDX) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                res_q[i] <= elemY;
                            end
                        end
                        if (opL_q == OP_VDOT) begin
                            acc_q <= acc_d;
                        end
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            weV_q   <= (opL_q != OP_VDOT);
                            weS_q   <= (opL_q == OP_VDOT);
                            state_q <= S_DONE;
                            if (opL_q == OP_VDOT) begin
                                dot_q <= acc_d;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we_v   = weV_q;
    assign we_s   = weS_q;
    assign vd_out = vd_q;
    assign res_0  = res_q[0];
    assign res_1  = res_q[1];
    assign res_2  = res_q[2];
    assign res_3  = res_q[3];
    assign res_4  = res_q[4];
    assign dot    = dot_q;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Self-checking bench for vec_exec_seq: directed cases from the test plan
// plus randomized operations checked against a plain arithmetic model.
module tb_vec_exec_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  opIn;
    logic [3:0]  vdIn;
    logic [31:0] tbA [5];
    logic [31:0] tbB [5];
    logic        busy, done, weV, weS;
    logic [3:0]  vdOut;
    logic [31:0] res0, res1, res2, res3, res4, dotOut;

    int checks;
    int failures;

    logic [31:0] modelDot;
    logic [31:0] expRes [5];

    vec_exec_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (opIn),
        .vd_in (vdIn),
        .a_0   (tbA[0]),
        .a_1   (tbA[1]),
        .a_2   (tbA[2]),
        .a_3   (tbA[3]),
        .a_4   (tbA[4]),
        .b_0   (tbB[0]),
        .b_1   (tbB[1]),
        .b_2   (tbB[2]),
        .b_3   (tbB[3]),
        .b_4   (tbB[4]),
        .busy  (busy),
        .done  (done),
        .we_v  (weV),
        .we_s  (weS),
        .vd_out(vdOut),
        .res_0 (res0),
        .res_1 (res1),
        .res_2 (res2),
        .res_3 (res3),
        .res_4 (res4),
        .dot   (dotOut)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a broken design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic logic [31:0] getRes(input int i);
        case (i)
            0: return res0;
            1: return res1;
            2: return res2;
            3: return res3;
            default: return res4;
        endcase
    endfunction

    // Arithmetic model of one element, straight from the operation rules
    function automatic logic [31:0] refElem(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] full;
        case (o)
            2'd0: return x + y;
            2'd1: return x - y;
            default: begin
                full = {32'd0, x} * {32'd0, y};
                return full[31:0];
            end
        endcase
    endfunction

    // Advance to one time unit after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive an operation request for the current cycle
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] vd);
        opIn  = o;
        vdIn  = vd;
        start = 1'b1;
    endtask

    task automatic randomizeOperands();
        for (int i = 0; i < 5; i++) begin
            tbA[i] = $urandom;
            tbB[i] = $urandom;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, "_busy"}, busy, 1'b0);
        checkBit({tag, "_done"}, done, 1'b0);
        checkBit({tag, "_we_v"}, weV, 1'b0);
        checkBit({tag, "_we_s"}, weS, 1'b0);
        checkOutput({tag, "_vd_out"}, {28'd0, vdOut}, 32'd0);
        checkOutput({tag, "_dot"}, dotOut, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_res%0d", tag, i), getRes(i), 32'd0);
        end
    endtask

    // Start an operation in the current cycle (cycle 0) and follow it to
    // cycle 7; optionally disturb the inputs and re-pulse start meanwhile
    task automatic runOp(input string tag, input logic [1:0] o, input logic [3:0] vd, input bit disturb);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 5; i++) begin
            expRes[i] = refElem(o, tbA[i], tbB[i]);
            sum = sum + expRes[i];
        end
        if (o == 2'd3) modelDot = sum;
        applyStimulus(o, vd);
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            start = disturb && (c == 3 || c == 6);
            if (disturb && c == 1) begin
                randomizeOperands();
                opIn = 2'($urandom_range(0, 3));
                vdIn = 4'($urandom_range(0, 15));
            end
            checkBit($sformatf("%s_busy_c%0d", tag, c), busy, 1'b1);
            checkBit($sformatf("%s_done_c%0d", tag, c), done, c == 6);
            if (c == 6) begin
                checkBit({tag, "_we_v"}, weV, o != 2'd3);
                checkBit({tag, "_we_s"}, weS, o == 2'd3);
                checkOutput({tag, "_vd_out"}, {28'd0, vdOut}, {28'd0, vd});
                checkOutput({tag, "_dot"}, dotOut, modelDot);
                for (int i = 0; i < 5; i++) begin
                    checkOutput($sformatf("%s_res%0d", tag, i), getRes(i), expRes[i]);
                end
            end else begin
                checkBit($sformatf("%s_we_v_c%0d", tag, c), weV, 1'b0);
                checkBit($sformatf("%s_we_s_c%0d", tag, c), weS, 1'b0);
            end
        end
        stepCycle();
        start = 1'b0;
        checkBit({tag, "_busy_c7"}, busy, 1'b0);
        checkBit({tag, "_done_c7"}, done, 1'b0);
        checkOutput({tag, "_hold_res0"}, res0, expRes[0]);
        checkOutput({tag, "_hold_dot"}, dotOut, modelDot);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelDot = 32'd0;
        reset    = 1'b1;
        start    = 1'b0;
        opIn     = 2'd0;
        vdIn     = 4'd0;
        for (int i = 0; i < 5; i++) begin
            tbA[i] = 32'd0;
            tbB[i] = 32'd0;
        end

        $display("[TB] reset and idle");
        stepCycle();
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkAllZero("reset");
        for (int c = 0; c < 10; c++) begin
            stepCycle();
            checkBit($sformatf("idle_done_%0d", c), done, 1'b0);
            checkBit($sformatf("idle_busy_%0d", c), busy, 1'b0);
        end

        $display("[TB] directed VADD");
        for (int i = 0; i < 5; i++) begin
            tbA[i] = 32'(i + 1);
            tbB[i] = 32'(10 * (i + 1));
        end
        runOp("vadd", 2'd0, 4'd7, 1'b0);
        checkOutput("vadd_res4_const", res4, 32'd55);

        $display("[TB] VSUB and VMUL wrap");
        randomizeOperands();
        tbA[0] = 32'd0;
        tbB[0] = 32'd1;
        runOp("vsub", 2'd1, 4'd3, 1'b0);
        checkOutput("vsub_wrap", res0, 32'hFFFF_FFFF);
        randomizeOperands();
        tbA[1] = 32'h0001_0000;
        tbB[1] = 32'h0001_0000;
        tbA[2] = 32'hFFFF_FFFF;
        tbB[2] = 32'd2;
        runOp("vmul", 2'd2, 4'd9, 1'b0);
        checkOutput("vmul_wrap1", res1, 32'h0000_0000);
        checkOutput("vmul_wrap2", res2, 32'hFFFF_FFFE);

        $display("[TB] VDOT then VADD keeps dot");
        for (int i = 0; i < 5; i++) begin
            tbA[i] = 32'(i + 1);
            tbB[i] = 32'(i + 1);
        end
        runOp("vdot", 2'd3, 4'd1, 1'b0);
        checkOutput("vdot_const", dotOut, 32'd55);
        randomizeOperands();
        runOp("vadd_after_dot", 2'd0, 4'd2, 1'b0);
        checkOutput("dot_hold", dotOut, 32'd55);

        $display("[TB] handshake robustness");
        randomizeOperands();
        runOp("hs", 2'($urandom_range(0, 3)), 4'd5, 1'b1);
        randomizeOperands();
        runOp("hs_next", 2'($urandom_range(0, 3)), 4'd6, 1'b0);

        $display("[TB] reset mid-operation");
        randomizeOperands();
        applyStimulus(2'd3, 4'd12);
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        modelDot = 32'd0;
        checkAllZero("midreset_c4");
        stepCycle();
        checkBit("midreset_c5_done", done, 1'b0);
        randomizeOperands();
        runOp("after_reset", 2'($urandom_range(0, 3)), 4'd11, 1'b0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            randomizeOperands();
            runOp($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), n % 5 == 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_exec_seq.md
Name: vec_exec_seq

Overview:
Element-serial vector execution unit downstream of the vector register file. It latches two 5-element source vectors (from vr1_*/vr2_*) on a start pulse and processes one element per cycle. It then issues a one-cycle write-back: either the full result vector (to the vector file wd2_*/we/vd2) or a scalar dot-product result. Only one operation is in flight at a time, with a start/busy/done handshake toward the control unit.

Parameters:
WIDTH, 32, element and scalar data width in bits
N_ELEM, 5, elements per vector; fixed by the register file, not to be overridden

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a new operation; accepted only in IDLE
op  in  2  operation: 00 VADD, 01 VSUB, 10 VMUL, 11 VDOT
vd_in  in  4  destination vector register number
a_0..a_4  in  WIDTH each  source vector A elements (from vr1_0..vr1_4)
b_0..b_4  in  WIDTH each  source vector B elements (from vr2_0..vr2_4)
busy  out  1  high in BUSY and DONE
done  out  1  one-cycle completion pulse
we_v  out  1  vector write enable to the register file; pulses with done when op != VDOT
we_s  out  1  scalar write enable; pulses with done when op == VDOT
vd_out  out  4  latched destination register number (to vd2)
res_0..res_4  out  WIDTH each  result elements (to wd2_0..wd2_4)
dot  out  WIDTH  dot-product scalar result

Behaviour:
- Reset (sync, active-high, wins over everything):
  - State goes to IDLE; idx=0; acc=0.
  - All outputs go to 0: res_*, dot, vd_out, busy, done, we_v, we_s.
- States: IDLE, BUSY, DONE, encoded in 2 bits.
- IDLE:
  - busy=0.
  - If start=1, latch a_*, b_*, op and vd_in; set idx=0 and acc=0; next state BUSY.
  - If start=0, remain in IDLE.
- BUSY, element idx processed each cycle:
  - res_idx <= f(op, a_idx, b_idx).
  - For VDOT: res_idx <= a_idx*b_idx (low WIDTH bits) and acc <= acc + a_idx*b_idx (low WIDTH bits).
  - idx increments each cycle; when idx==4, next state DONE and dot <= final acc (applies for VDOT only).
- DONE, exactly one cycle:
  - done=1.
  - we_v=(op_l!=VDOT), we_s=(op_l==VDOT).
  - Next state IDLE.
- Arithmetic, all modulo 2^WIDTH with no flags and no saturation:
  - VADD: a+b.
  - VSUB: a-b.
  - VMUL: low WIDTH bits of the product (sign-agnostic).
- Latency:
  - start sampled high in cycle 0 -> BUSY in cycles 1-5 -> done/we in cycle 6 -> IDLE in cycle 7.
  - The earliest next start is accepted in cycle 7, giving a throughput of one operation per 7 cycles.
- Start handling:
  - start while busy=1 is ignored; no queuing, and the latched operands are unaffected.
- Operand stability:
  - Changes on a_*/b_*/op/vd_in after the start cycle have no effect. This permits the register file read ports to be repurposed during execution.
- Result visibility:
  - res_* change element by element during BUSY and are valid only when done=1.
  - res_*, dot and vd_out hold their values after DONE until the next accepted start.
  - dot is updated only by VDOT operations.
- Reset mid-operation (any BUSY/DONE cycle):
  - No done, we_v or we_s is emitted; all outputs read 0 next cycle.
- idx never exceeds 4; values 5-7 are unreachable.
  - If idx is forced out of range, the FSM returns to IDLE without write-back.

Decomposition:
- Package vec_pkg:
  - op encodings OP_VADD/OP_VSUB/OP_VMUL/OP_VDOT.
  - N_ELEM=5 and the IDX_W=3 index width.
  - FSM state encodings S_IDLE/S_BUSY/S_DONE.
- Sub-module vec_elem_alu: combinational single-element op unit (op, a, b -> y) feeding both res_idx and the accumulator. It is instantiated once and time-multiplexed by idx.
- The FSM, operand latches and accumulator stay in vec_exec_seq.

Test Plan:
- Reset and idle: assert reset for 2 cycles, release.
  - All outputs are 0 and busy=0.
  - Holding start=0 for 10 cycles produces no done.
- VADD:
  - Stimulus: a={1,2,3,4,5}, b={10,20,30,40,50}, vd_in=7, start pulse in cycle 0.
  - Response: done=we_v=1 only in cycle 6, we_s=0, res={11,22,33,44,55}, vd_out=7, busy high in cycles 1-6.
- VSUB/VMUL wrap:
  - VSUB with a_0=0, b_0=1 gives res_0=0xFFFFFFFF.
  - VMUL with a_1=0x00010000, b_1=0x00010000 gives res_1=0x00000000.
  - VMUL with a_2=0xFFFFFFFF, b_2=2 gives res_2=0xFFFFFFFE.
- VDOT:
  - Stimulus: a={1,2,3,4,5}, b={1,2,3,4,5}.
  - Response in cycle 6: dot=55, we_s=1, we_v=0, res={1,4,9,16,25}.
  - A following VADD leaves dot=55 unchanged.
- Handshake robustness:
  - Stimulus: after start in cycle 0, change a_*/b_*/op in cycle 1 and pulse start in cycles 3 and 6.
  - Response: the result reflects the cycle-0 operands, exactly one done occurs (cycle 6), and a start in cycle 7 is accepted (done in cycle 13).
- Reset mid-operation: start in cycle 0, reset in cycle 3.
  - From cycle 4 all outputs are 0 and there is no done, we_v or we_s pulse.
  - A new start in cycle 5 completes normally with done in cycle 11.
